async_fifo_tmpl: RTL and testbench

//  Single-clock build of the team FIFO template: DW-bit data, 2**AW-entry circular buffer.

---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/fifo_ptr_sync.sv | 42 ++++
 rtl/async_fifo_tmpl.sv | 142 ++++++++++++++
 tb/tb_async_fifo_tmpl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the FIFO template.
package async_fifo_pkg;

    localparam int AW_DEF = 4;
    localparam int DEPTH  = 1 << AW_DEF;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Gray-pointer delay line of SYNC_STAGES flops; flush clears every stage synchronously.
module fifo_ptr_sync #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_d[i] = '0;
        end
        if (!flush) begin
            stage_d[0] = d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_tmpl.sv
// Single-clock FIFO keeping the dual-clock Gray-pointer structure and flag latency.
// Optional sticky error outputs are enabled with ASYNC_FIFO_ERR_FLAGS_EN.
module async_fifo_tmpl
    import async_fifo_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = AW_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_sw_rst,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_wr_valid,
    output logic          o_wr_fifo_full,
    input  logic          rd_sw_rst,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic          o_rd_fifo_empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic          o_wr_overflow,
    output logic          o_rd_underflow
`endif
);

    localparam int PW        = AW + 1;
    localparam int MEM_DEPTH = 1 << AW;

    logic [DW-1:0] mem [MEM_DEPTH];

    logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
    logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [PW-1:0] wr_gray_sync, rd_gray_sync;
    logic          flush, full, empty, wr_accept, rd_accept;

    always_comb begin
        flush     = wr_sw_rst | rd_sw_rst;
        empty     = (rd_gray_q == wr_gray_sync);
        // Full when the write pointer is a whole lap ahead: top two Gray bits inverted.
        full      = (wr_gray_q == {~rd_gray_sync[AW:AW-1], rd_gray_sync[AW-2:0]});
        wr_accept = i_wr_valid & ~full;
        rd_accept = i_rd_en & ~empty;

        wr_bin_d   = wr_bin_q + PW'(wr_accept);
        rd_bin_d   = rd_bin_q + PW'(rd_accept);
        rd_data_d  = rd_accept ? mem[rd_bin_q[AW-1:0]] : rd_data_q;
        rd_valid_d = rd_accept;

        if (flush) begin
            wr_bin_d   = '0;
            rd_bin_d   = '0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
        end

        wr_gray_d = PW'(bin2gray(32'(wr_bin_d)));
        rd_gray_d = PW'(bin2gray(32'(rd_bin_d)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bin_q   <= '0;
            wr_gray_q  <= '0;
            rd_bin_q   <= '0;
            rd_gray_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush) begin
            mem[wr_bin_q[AW-1:0]] <= i_wr_data;
        end
    end

    fifo_ptr_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr2rd_sync (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .d     (wr_gray_q),
        .q     (wr_gray_sync)
    );

    fifo_ptr_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd2wr_sync (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .d     (rd_gray_q),
        .q     (rd_gray_sync)
    );

    assign o_wr_fifo_full  = full;
    assign o_rd_fifo_empty = empty;
    assign o_rd_data       = rd_data_q;
    assign o_rd_valid      = rd_valid_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (i_wr_valid & full);
        underflow_d = underflow_q | (i_rd_en & empty);
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_wr_overflow  = overflow_q;
    assign o_rd_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_tmpl.sv
// Self-checking bench for async_fifo_tmpl against a queue/occupancy-count reference model.
module tb_async_fifo_tmpl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int SS    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk, rst, wr_sw_rst, rd_sw_rst, i_wr_valid, i_rd_en;
    logic [DW-1:0] i_wr_data, o_rd_data;
    logic          o_wr_fifo_full, o_rd_valid, o_rd_fifo_empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic          o_wr_overflow, o_rd_underflow;
`endif

    async_fifo_tmpl #(.DW(DW), .AW(AW), .SYNC_STAGES(SS)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_sw_rst       (wr_sw_rst),
        .i_wr_data       (i_wr_data),
        .i_wr_valid      (i_wr_valid),
        .o_wr_fifo_full  (o_wr_fifo_full),
        .rd_sw_rst       (rd_sw_rst),
        .i_rd_en         (i_rd_en),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .o_rd_fifo_empty (o_rd_fifo_empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .o_wr_overflow   (o_wr_overflow),
        .o_rd_underflow  (o_rd_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    // Reference model: total words written/read, their delayed copies, and the data queue.
    int            wc, rc;
    int            wc_hist [SS];
    int            rc_hist [SS];
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_data;
    logic          exp_valid, exp_ovf, exp_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wc = 0;
        rc = 0;
        for (int i = 0; i < SS; i++) begin
            wc_hist[i] = 0;
            rc_hist[i] = 0;
        end
        q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    // One clock edge: capture requests, advance the model, compare every output.
    task automatic step();
        logic          fl, wv, re, full_pre, empty_pre;
        logic [DW-1:0] wd;
        fl        = wr_sw_rst | rd_sw_rst;
        wv        = i_wr_valid;
        re        = i_rd_en;
        wd        = i_wr_data;
        full_pre  = o_wr_fifo_full;
        empty_pre = o_rd_fifo_empty;
        @(posedge clk);
        #1;
        if (fl) begin
            model_reset();
        end else begin
            for (int i = SS - 1; i > 0; i--) begin
                wc_hist[i] = wc_hist[i-1];
                rc_hist[i] = rc_hist[i-1];
            end
            wc_hist[0] = wc;
            rc_hist[0] = rc;
            if (wv && full_pre === 1'b0) begin
                q.push_back(wd);
                wc++;
            end
            exp_valid = 1'b0;
            if (re && empty_pre === 1'b0) begin
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL read_while_model_empty: observed size %0d expected nonzero", q.size());
                end
                if (q.size() != 0) exp_data = q.pop_front();
                exp_valid = 1'b1;
                rc++;
            end
            if (wv && full_pre) exp_ovf = 1'b1;
            if (re && empty_pre) exp_unf = 1'b1;
        end
        chk("empty", 32'(o_rd_fifo_empty), 32'(rc == wc_hist[SS-1]));
        chk("full", 32'(o_wr_fifo_full), 32'((wc - rc_hist[SS-1]) == DEPTH));
        chk("rd_valid", 32'(o_rd_valid), 32'(exp_valid));
        chk("rd_data", 32'(o_rd_data), 32'(exp_data));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(o_wr_overflow), 32'(exp_ovf));
        chk("underflow", 32'(o_rd_underflow), 32'(exp_unf));
`endif
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] nexp;
        logic          wacc_pre;
        int            nread;

        rst = 1'b0; wr_sw_rst = 1'b0; rd_sw_rst = 1'b0;
        i_wr_valid = 1'b0; i_rd_en = 1'b0; i_wr_data = '0;
        model_reset();
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_empty", 32'(o_rd_fifo_empty), 32'd1);
        chk("rst_full", 32'(o_wr_fifo_full), 32'd0);
        chk("rst_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_data", 32'(o_rd_data), 32'd0);
        rst = 1'b0;
        step(); step();

        // Single word: empty falls two edges after the write edge.
        i_wr_valid = 1'b1; i_wr_data = 8'hA5;
        step();
        i_wr_valid = 1'b0;
        step();
        chk("a5_empty_e1", 32'(o_rd_fifo_empty), 32'd1);
        step();
        chk("a5_empty_e2", 32'(o_rd_fifo_empty), 32'd0);
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("a5_data", 32'(o_rd_data), 32'hA5);
        chk("a5_valid", 32'(o_rd_valid), 32'd1);
        step();
        chk("a5_valid_drop", 32'(o_rd_valid), 32'd0);
        chk("a5_data_hold", 32'(o_rd_data), 32'hA5);
        step(); step();

        // Fill to full with a holding producer, then free one slot.
        rd_sw_rst = 1'b1; step(); rd_sw_rst = 1'b0;
        d = 8'd1;
        for (int i = 0; i < 22; i++) begin
            i_wr_valid = 1'b1; i_wr_data = d;
            wacc_pre = !o_wr_fifo_full;
            step();
            if (wacc_pre) d++;
        end
        chk("fill_full", 32'(o_wr_fifo_full), 32'd1);
        chk("fill_accepted", 32'(d), 32'd17);
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("fill_first_out", 32'(o_rd_data), 32'd1);
        for (int i = 0; i < 4; i++) begin
            i_wr_valid = 1'b1; i_wr_data = d;
            wacc_pre = !o_wr_fifo_full;
            step();
            if (wacc_pre) d++;
        end
        i_wr_valid = 1'b0;
        chk("word17_accepted", 32'(d), 32'd18);
        for (int i = 0; i < 40 && !(o_rd_valid && o_rd_data == 8'd17); i++) begin
            i_rd_en = !o_rd_fifo_empty;
            step();
        end
        i_rd_en = 1'b0;
        chk("drain_last", 32'(o_rd_data), 32'd17);
        step();

        // Randomised streaming; the pointers lap the 32-state space more than twice.
        wr_sw_rst = 1'b1; step(); wr_sw_rst = 1'b0;
        d = 8'd1; nexp = 8'd1; nread = 0;
        for (int cyc = 0; cyc < 3000 && nread < 80; cyc++) begin
            i_wr_valid = ($urandom_range(0, 3) != 0);
            i_wr_data  = d;
            i_rd_en    = !o_rd_fifo_empty && ($urandom_range(0, 3) != 0);
            wacc_pre   = i_wr_valid && !o_wr_fifo_full;
            step();
            if (wacc_pre) d++;
            if (o_rd_valid) begin
                chk("stream_seq", 32'(o_rd_data), 32'(nexp));
                nexp++;
                nread++;
            end
        end
        i_wr_valid = 1'b0; i_rd_en = 1'b0;
        chk("stream_done", 32'(nread >= 80), 32'd1);

        // Async reset mid-stream while a read strobe is active.
        for (int i = 0; i < 5; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'(8'h50 + i);
            step();
        end
        i_wr_valid = 1'b0;
        step(); step();
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("pre_rst_valid", 32'(o_rd_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(o_rd_fifo_empty), 32'd1);
        chk("async_rst_valid", 32'(o_rd_valid), 32'd0);
        chk("async_rst_data", 32'(o_rd_data), 32'd0);
        #1 rst = 1'b0;
        model_reset();
        step();

        // Soft flush, then a fresh word must come back.
        for (int i = 0; i < 5; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'(8'h60 + i);
            step();
        end
        i_wr_valid = 1'b0;
        step(); step();
        wr_sw_rst = 1'b1;
        step();
        wr_sw_rst = 1'b0;
        chk("swrst_empty", 32'(o_rd_fifo_empty), 32'd1);
        i_wr_valid = 1'b1; i_wr_data = 8'h3C;
        step();
        i_wr_valid = 1'b0;
        step(); step();
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("swrst_new_word", 32'(o_rd_data), 32'h3C);
        step();

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        step(); step();
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("err_underflow", 32'(o_rd_underflow), 32'd1);
        step(); step();
        chk("err_underflow_sticky", 32'(o_rd_underflow), 32'd1);
        for (int i = 0; i < 18; i++) begin
            i_wr_valid = 1'b1; i_wr_data = 8'(8'h80 + i);
            step();
        end
        i_wr_valid = 1'b0;
        chk("err_overflow", 32'(o_wr_overflow), 32'd1);
        i_rd_en = 1'b1;
        step();
        i_rd_en = 1'b0;
        chk("err_contents", 32'(o_rd_data), 32'h80);
        rd_sw_rst = 1'b1;
        step();
        rd_sw_rst = 1'b0;
        chk("err_clear", 32'({o_wr_overflow, o_rd_underflow}), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
